dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the data memory's single write path between the CPU store port and the keyboard writer.
// - Keyboard writes are buffered in a FIFO, so they are never lost when the CPU writes in the same cycle.
// - Sits between the CPU/keyboard controller and data memory:
//   - drives the memory's CPU port (we/a/wd) and keyboard port (we_kb/addr_kb/data_kb);
//   - guarantees that both write enables are never high in the same cycle.
// - Starvation guard: stalls the CPU for one cycle when a keyboard write has waited too long.
// PARAMETERS
// - KB_FIFO_DEPTH  4   keyboard write FIFO entries (power of 2, >=2)
// - MAX_WAIT       8   cycles a FIFO head may wait before a forced drain (>=1)
// - MEM_WORDS      64  memory size in words; keyboard writes with addr[31:2] >= MEM_WORDS are rejected
// PORTS
// - clk            in   1   system clock, rising edge
// - rst            in   1   asynchronous reset, active-high
// - cpu_we         in   1   CPU store request
// - cpu_a          in   32  CPU byte address
// - cpu_wd         in   32  CPU store data
// - cpu_stall      out  1   CPU must hold cpu_we/cpu_a/cpu_wd this cycle
// - kb_valid       in   1   keyboard write request
// - kb_addr        in   32  keyboard byte address
// - kb_data        in   32  keyboard write data
// - kb_ready       out  1   FIFO can accept (= !full)
// - kb_err         out  1   1-cycle pulse: out-of-range keyboard write was dropped
// - mem_we         out  1   to memory we
// - mem_a          out  32  to memory a (= cpu_a)
// - mem_wd         out  32  to memory wd (= cpu_wd)
// - mem_we_kb      out  1   to memory we_kb
// - mem_addr_kb    out  32  to memory addr_kb (FIFO head addr)
// - mem_data_kb    out  32  to memory data_kb (FIFO head data)
// - stat_forced    out  16  forced-drain count (see CONFIGURATION)
// - stat_dropped   out  16  out-of-range drop count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst=1):
//   - FIFO empty, wait counter 0, state IDLE, statistics counters 0.
//   - kb_ready=1, kb_err=0, cpu_stall=0, mem_we=0, mem_we_kb=0.
// - Accept: kb_valid && kb_ready at posedge.
//   - In-range entry is pushed.
//   - Out-of-range entry is not pushed; kb_err=1 in the next cycle only.
// - Push when full is impossible (kb_ready=0). Push and pop in the same cycle is legal when not full.
// - Latency: an accepted entry appears at the FIFO head no earlier than the next cycle.
// - FIFO pointers are log2(KB_FIFO_DEPTH) bits plus one wrap bit, and wrap modulo the depth.
// - FSM:
//   - IDLE: FIFO empty; mem_we=cpu_we, mem_we_kb=0. Go to PEND when the FIFO becomes non-empty.
//   - PEND: CPU has priority.
//     - mem_we=cpu_we; mem_we_kb = !cpu_we, and popping occurs on that edge.
//     - Pop: go to IDLE if the FIFO becomes empty, else stay in PEND with the wait counter cleared.
//     - No pop: wait counter +1. On reaching MAX_WAIT, go to FORCE.
//   - FORCE (exactly 1 cycle):
//     - cpu_stall=1, mem_we=0, mem_we_kb=1, pop the head, wait counter cleared.
//     - Next state: IDLE if empty, else PEND.
// - Outputs in IDLE/PEND: cpu_stall=0. cpu_stall, mem_we and mem_we_kb are combinational from state, FIFO empty and cpu_we.
// - Invariant: mem_we && mem_we_kb is never 1.
// - A pending CPU store during FORCE is completed in the following cycle (CPU holds its request).
// - Reset mid-operation: buffered entries are discarded; no memory write occurs while rst=1.
// CONFIGURATION
// - DMEM_ARB_STATS_EN defined:
//   - stat_forced +1 per FORCE cycle; stat_dropped +1 per kb_err pulse.
//   - Both saturate at 16'hFFFF and clear only on rst.
// - DMEM_ARB_STATS_EN undefined: both counters absent, stat_forced=stat_dropped=16'h0000 constant.
// TESTING
// - Reset, then kb write addr=0x10 data=0xA5 with cpu_we=0
//   -> mem_we_kb=1, mem_addr_kb=0x10, mem_data_kb=0xA5 one cycle after accept.
// - Same-cycle cpu_we=1 (a=0x20, wd=0x11) and kb write (0x24, 0x22)
//   -> cycle+1: mem_we=1 only; next cycle with cpu_we=0: mem_we_kb=1 at 0x24.
// - cpu_we held at 1 with one entry queued, MAX_WAIT=8
//   -> on the 9th cycle cpu_stall=1, mem_we=0, mem_we_kb=1; stat_forced=1 (STATS_EN).
// - 5 back-to-back kb writes with cpu_we=1, depth 4
//   -> kb_ready=0 after 4 accepts; 5th held until a pop; all 5 written in order.
// - kb write addr=0x100 (word 64)
//   -> no enqueue, kb_err pulse 1 cycle, stat_dropped=1 (STATS_EN) / 0 (undefined).
// - rst asserted with 3 entries queued
//   -> immediately mem_we_kb=0, kb_ready=1; after release no stale write occurs.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory write path between CPU stores and
// a FIFO-buffered keyboard writer. Optional statistics under DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int KB_FIFO_DEPTH = 4,
  parameter int MAX_WAIT      = 8,
  parameter int MEM_WORDS     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  input  logic        kb_valid,
  input  logic [31:0] kb_addr,
  input  logic [31:0] kb_data,
  output logic        kb_ready,
  output logic        kb_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we_kb,
  output logic [31:0] mem_addr_kb,
  output logic [31:0] mem_data_kb,
  output logic [15:0] stat_forced,
  output logic [15:0] stat_dropped
);

  localparam int AW = $clog2(KB_FIFO_DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [29:0] MW = 30'(MEM_WORDS);
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   wptr_n;
  logic [AW:0]   rptr_n;
  logic [31:0]   fifo_addr [KB_FIFO_DEPTH];
  logic [31:0]   fifo_data [KB_FIFO_DEPTH];

  logic empty;
  logic full;
  logic empty_n;
  logic in_range;
  logic accept;
  logic push;
  logic pop;
  logic drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign kb_ready = !full;
  assign in_range = (kb_addr[31:2] < MW);
  assign accept   = kb_valid && !full;
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;

  assign pop     = mem_we_kb;
  assign wptr_n  = wptr + (AW+1)'(push);
  assign rptr_n  = rptr + (AW+1)'(pop);
  assign empty_n = (wptr_n == rptr_n);

  assign mem_a       = cpu_a;
  assign mem_wd      = cpu_wd;
  assign mem_addr_kb = fifo_addr[rptr[AW-1:0]];
  assign mem_data_kb = fifo_data[rptr[AW-1:0]];

  // Port steering: CPU first, keyboard on idle CPU cycles or forced drain.
  always_comb begin
    cpu_stall = 1'b0;
    mem_we    = 1'b0;
    mem_we_kb = 1'b0;
    unique case (state)
      IDLE: begin
        mem_we = cpu_we && !rst;
      end
      PEND: begin
        mem_we    = cpu_we && !rst;
        mem_we_kb = !cpu_we && !empty && !rst;
      end
      FORCE: begin
        cpu_stall = 1'b1;
        mem_we_kb = !empty && !rst;
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
  end

  // FIFO read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr[AW-1:0]] <= kb_addr;
      fifo_data[wptr[AW-1:0]] <= kb_data;
    end
  end

  // One-cycle error pulse for a dropped out-of-range write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_err <= 1'b0;
    end else begin
      kb_err <= drop;
    end
  end

  // Arbitration FSM with starvation counter on the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!empty_n) state <= PEND;
        end
        PEND: begin
          if (pop) begin
            wait_cnt <= '0;
            state    <= empty_n ? IDLE : PEND;
          end else if (wait_cnt == WLAST) begin
            wait_cnt <= '0;
            state    <= FORCE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FORCE: begin
          wait_cnt <= '0;
          state    <= empty_n ? IDLE : PEND;
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating forced-drain and dropped-write counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_forced  <= '0;
      stat_dropped <= '0;
    end else begin
      if (state == FORCE && stat_forced != 16'hFFFF)
        stat_forced <= stat_forced + 16'd1;
      if (drop && stat_dropped != 16'hFFFF)
        stat_dropped <= stat_dropped + 16'd1;
    end
  end
`else
  assign stat_forced  = 16'h0000;
  assign stat_dropped = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  localparam int MEMW  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic        cpu_stall;
  logic        kb_valid;
  logic [31:0] kb_addr;
  logic [31:0] kb_data;
  logic        kb_ready;
  logic        kb_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we_kb;
  logic [31:0] mem_addr_kb;
  logic [31:0] mem_data_kb;
  logic [15:0] stat_forced;
  logic [15:0] stat_dropped;

  dmem_port_arbiter #(
    .KB_FIFO_DEPTH(DEPTH),
    .MAX_WAIT(MAXW),
    .MEM_WORDS(MEMW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_stall(cpu_stall),
    .kb_valid(kb_valid), .kb_addr(kb_addr), .kb_data(kb_data),
    .kb_ready(kb_ready), .kb_err(kb_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_we_kb(mem_we_kb), .mem_addr_kb(mem_addr_kb),
    .mem_data_kb(mem_data_kb),
    .stat_forced(stat_forced), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  logic [63:0] q[$];
  int  wt;
  bit  frc;
  bit  err_exp;
  int  nforced;
  int  ndrop;
  bit  last_stall;
  bit  last_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wt      = 0;
    frc     = 0;
    err_exp = 0;
    nforced = 0;
    ndrop   = 0;
  endtask

  task automatic tick();
    logic e_stall, e_we, e_wekb;
    logic [63:0] hd;
    bit acc, inr, had;
    #1;
    had     = (q.size() != 0);
    e_stall = frc;
    if (frc) begin
      e_we   = 1'b0;
      e_wekb = 1'b1;
    end else begin
      e_we   = cpu_we;
      e_wekb = had && !cpu_we;
    end
    chk("stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_we_kb", {31'd0, mem_we_kb}, {31'd0, e_wekb});
    chk("both_we", {31'd0, mem_we && mem_we_kb}, 32'd0);
    chk("kb_ready", {31'd0, kb_ready},
        {31'd0, q.size() < DEPTH});
    chk("kb_err", {31'd0, kb_err}, {31'd0, err_exp});
    chk("mem_a", mem_a, cpu_a);
    chk("mem_wd", mem_wd, cpu_wd);
    if (e_wekb) begin
      hd = q[0];
      chk("kb_addr_out", mem_addr_kb, hd[63:32]);
      chk("kb_data_out", mem_data_kb, hd[31:0]);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_forced", {16'd0, stat_forced}, 32'(nforced));
    chk("stat_dropped", {16'd0, stat_dropped}, 32'(ndrop));
`else
    chk("stat_forced", {16'd0, stat_forced}, 32'd0);
    chk("stat_dropped", {16'd0, stat_dropped}, 32'd0);
`endif
    acc = kb_valid && (q.size() < DEPTH);
    inr = (kb_addr[31:2] < MEMW);
    @(posedge clk);
    if (e_wekb) void'(q.pop_front());
    if (acc && inr) q.push_back({kb_addr, kb_data});
    err_exp = acc && !inr;
    if (err_exp && ndrop < 65535) ndrop++;
    if (frc) begin
      frc = 0;
      wt  = 0;
      if (nforced < 65535) nforced++;
    end else if (had && !e_wekb) begin
      wt++;
      if (wt == MAXW) begin
        frc = 1;
        wt  = 0;
      end
    end else begin
      wt = 0;
    end
    last_stall = e_stall;
    last_acc   = acc;
    @(negedge clk);
  endtask

  task automatic kb(input logic [31:0] a, input logic [31:0] d);
    kb_valid = 1'b1;
    kb_addr  = a;
    kb_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    cpu_we = 1'b1; cpu_a = 32'h0; cpu_wd = 32'h0;
    kb_valid = 1'b0; kb_addr = 32'h0; kb_data = 32'h0;
    last_stall = 0; last_acc = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_we_kb", {31'd0, mem_we_kb}, 32'd0);
    chk("rst_ready", {31'd0, kb_ready}, 32'd1);
    chk("rst_err", {31'd0, kb_err}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_we = 1'b0;

    kb(32'h10, 32'hA5);
    tick();
    kb_valid = 1'b0;
    tick();
    tick();

    cpu_we = 1'b1; cpu_a = 32'h20; cpu_wd = 32'h11;
    kb(32'h24, 32'h22);
    tick();
    kb_valid = 1'b0;
    tick();
    cpu_we = 1'b0;
    tick();
    tick();

    cpu_we = 1'b1; cpu_a = 32'h30; cpu_wd = 32'h33;
    kb(32'h28, 32'h44);
    tick();
    kb_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    cpu_we = 1'b0;
    tick();

    cpu_we = 1'b1; cpu_a = 32'h34; cpu_wd = 32'h55;
    for (int i = 0; i < 5; i++) begin
      kb(32'h40 + 32'(i * 4), 32'h100 + 32'(i));
      tick();
      for (int k = 0; k < 40 && !last_acc; k++) tick();
    end
    kb_valid = 1'b0;
    cpu_we = 1'b0;
    for (int k = 0; k < 7; k++) tick();

    kb(32'h100, 32'hDEAD);
    tick();
    kb_valid = 1'b0;
    tick();
    tick();

    cpu_we = 1'b1; cpu_a = 32'h3C; cpu_wd = 32'h66;
    for (int i = 0; i < 3; i++) begin
      kb(32'h50 + 32'(i * 4), 32'h200 + 32'(i));
      tick();
    end
    kb_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_we_kb", {31'd0, mem_we_kb}, 32'd0);
    chk("midrst_ready", {31'd0, kb_ready}, 32'd1);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cpu_we = 1'b0;
    last_stall = 0; last_acc = 0;
    for (int k = 0; k < 4; k++) tick();

    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        cpu_we = ($urandom_range(0, 9) < 7);
        cpu_a  = $urandom;
        cpu_wd = $urandom;
      end
      if (!(kb_valid && !last_acc)) begin
        kb_valid = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0)
          kb_addr = 32'h100 + (32'($urandom_range(0, 63)) << 2);
        else
          kb_addr = 32'($urandom_range(0, 63)) << 2;
        kb_data = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
